game_input_cond: RTL and testbench
==================================

# game_input_cond

Input conditioner feeding the game core's `pushin`, `began`, `paus`, `quit` and `choice` inputs from raw board buttons and switches. It synchronises, debounces and edge-detects all seven raw lines. It delivers one-cycle press pulses for the four buttons and a glitch-free 3-bit difficulty choice to the game core. All logic runs in the single system clock domain.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable samples required before a debounced level changes; minimum 2.
- `REPEAT_DELAY`, default 25_000_000: cycles from a `pushin` press pulse to its first auto-repeat pulse. Used only with `AUTOREPEAT_EN`.
- `REPEAT_PERIOD`, default 6_250_000: cycles between subsequent auto-repeat pulses. Used only with `AUTOREPEAT_EN`.
- `clk` in 1: system clock.
- `rst_n` in 1: synchronous, active-low reset.
- `btn_raw` in 4: asynchronous buttons; bit 0 flap (`pushin`), bit 1 start (`began`), bit 2 pause (`paus`), bit 3 quit.
- `sw_raw` in 3: asynchronous difficulty switches.
- `btn_level` out 4: debounced button levels.
- `btn_press` out 4: one-cycle pulse on each debounced rising edge.
- `choice` out 3: debounced switch value.
- `choice_chg` out 1: one-cycle pulse when `choice` changes.

## Operation
- Each of the 7 raw lines passes through a 2-flop synchroniser (`s1` → `s2`), then a debounce counter.
- Counter behaviour:
  - When `s2` ≠ stable, the counter increments.
  - When the counter reaches `DEBOUNCE_CYCLES-1` while still mismatched, stable takes `s2` and the counter clears.
  - When `s2` = stable, the counter clears. A bounce therefore restarts the count.
- Counter width is `$clog2(DEBOUNCE_CYCLES)`. It never wraps, because it clears at the terminal count.
- `btn_press[i]` = registered (next stable & ~stable). Falling edges produce no pulse.
- `choice_chg` is registered: it is high when any `choice` bit changes value.
- Simultaneous edges on several buttons give simultaneous pulses. There is no priority or masking; the game core arbitrates.
- `choice` bits debounce independently. Bits settling on different cycles produce one `choice_chg` pulse per settling cycle.
- Reset state: synchronisers, counters, stable levels, all outputs and repeat state are 0.
- Reset asserted mid-count discards the partial count.
- A button held through reset release produces a press pulse after the normal latency. A nonzero switch held through reset produces a `choice_chg` pulse.

## Timing
- Latency: raw change first sampled at edge k, held steady → `btn_level`/`choice` update and pulse high after edge k+1+`DEBOUNCE_CYCLES`. That is `DEBOUNCE_CYCLES`+2 edges inclusive of the sampling edge.
- Pulse width: exactly 1 cycle.
- Minimum spacing between two press pulses on one button: 2·`DEBOUNCE_CYCLES` cycles (one release plus one press).
- A glitch shorter than `DEBOUNCE_CYCLES` samples never reaches the outputs.
- All outputs are registered. There are no combinational paths from inputs.

## Configuration
- `GAME_INPUT_AUTOREPEAT_EN` defined:
  - While `btn_level[0]` stays high, `btn_press[0]` also pulses `REPEAT_DELAY` cycles after the press pulse.
  - It then pulses every `REPEAT_PERIOD` cycles after that.
  - Release clears the repeat counter immediately. A pulse scheduled for the release cycle is suppressed.
  - Bits 1–3 never repeat.
- Macro undefined:
  - One pulse per press.
  - Repeat counter and logic are absent.
  - `REPEAT_*` parameters are ignored.

## Structure
- Shared package `game_input_pkg` holds:
  - Button index constants `BTN_FLAP=0`, `BTN_START=1`, `BTN_PAUSE=2`, `BTN_QUIT=3`.
  - `NUM_BTN=4` and `CHOICE_W=3`.
- Sub-module `debounce_ch` (1-bit: synchroniser, counter, stable flop, rise flag; parameter `DEBOUNCE_CYCLES`), instantiated 7 times.
- The top level holds the `choice_chg` compare and the optional repeat logic.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=5.
- Clean press: `btn_raw`=0001 from edge 0, held → `btn_level[0]`=1 and a single `btn_press[0]` pulse after edge 5; no pulse on release.
- Bounce: `btn_raw[3]` toggles 1,0,1,0 on alternate cycles, then stays 1 → no output until 4 steady samples after the last toggle, then one `btn_press[3]` pulse.
- Simultaneous: `btn_raw`=0110 in one cycle → `btn_press`=0110 in the same cycle.
- Choice: `sw_raw` 000→101 → `choice`=101 after edge 5, with one `choice_chg` pulse; a 2-cycle glitch to 111 → no change.
- Reset mid-count: `btn_raw[1]`=1, `rst_n`=0 at edge 3 for one cycle, button held → pulse 6 edges after reset release, not before.
- `GAME_INPUT_AUTOREPEAT_EN`: hold flap 40 cycles → press pulse at edge 5, repeats at 15, 20, 25, 30, 35, 40; release → pulses stop. With the macro undefined, only the edge-5 pulse appears.

Source files
------------

// File: rtl/game_input_pkg.sv
// Shared constants for the game input conditioner: button indices and channel widths.
package game_input_pkg;
   localparam int NUM_BTN   = 4;
   localparam int CHOICE_W  = 3;
   localparam int BTN_FLAP  = 0;
   localparam int BTN_START = 1;
   localparam int BTN_PAUSE = 2;
   localparam int BTN_QUIT  = 3;
endpackage

// File: rtl/game_input_cond_debounce_ch.sv
// One raw line: 2-flop synchroniser, mismatch counter, stable level and registered rise flag.
module debounce_ch #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_raw,
   output logic o_level,
   output logic o_rise,
   output logic o_chg_next
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_s1;
   logic             r_s2;
   logic             r_stable;
   logic             r_rise;
   logic [CNT_W-1:0] r_cnt;
   logic             w_stable_next;
   logic [CNT_W-1:0] w_cnt_next;

   // Any sample that agrees with the stable level restarts the count.
   always_comb begin
      w_stable_next = r_stable;
      w_cnt_next    = '0;
      if (r_s2 != r_stable) begin
         if (r_cnt == CNT_TERM) begin
            w_stable_next = r_s2;
         end else begin
            w_cnt_next = r_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1     <= 1'b0;
         r_s2     <= 1'b0;
         r_cnt    <= '0;
         r_stable <= 1'b0;
         r_rise   <= 1'b0;
      end else begin
         r_s1     <= i_raw;
         r_s2     <= r_s1;
         r_cnt    <= w_cnt_next;
         r_stable <= w_stable_next;
         r_rise   <= w_stable_next & ~r_stable;
      end
   end

   assign o_level    = r_stable;
   assign o_rise     = r_rise;
   assign o_chg_next = w_stable_next ^ r_stable;
endmodule

// File: rtl/game_input_cond.sv
// Conditions board buttons and difficulty switches for the game core.
// Optional flap auto-repeat is built when GAME_INPUT_AUTOREPEAT_EN is defined.
module game_input_cond
   import game_input_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int REPEAT_DELAY    = 25_000_000,
   parameter int REPEAT_PERIOD   = 6_250_000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_BTN-1:0]  btn_raw,
   input  logic [CHOICE_W-1:0] sw_raw,
   output logic [NUM_BTN-1:0]  btn_level,
   output logic [NUM_BTN-1:0]  btn_press,
   output logic [CHOICE_W-1:0] choice,
   output logic                choice_chg
);
   logic [NUM_BTN-1:0]  w_btn_level;
   logic [NUM_BTN-1:0]  w_btn_rise;
   logic [NUM_BTN-1:0]  w_btn_chg_next;
   logic [CHOICE_W-1:0] w_sw_level;
   logic [CHOICE_W-1:0] w_sw_rise;
   logic [CHOICE_W-1:0] w_sw_chg_next;
   logic                r_choice_chg;
   logic                w_unused;

   genvar gi;
   for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
         .clk        (clk),
         .rst_n      (rst_n),
         .i_raw      (btn_raw[gi]),
         .o_level    (w_btn_level[gi]),
         .o_rise     (w_btn_rise[gi]),
         .o_chg_next (w_btn_chg_next[gi])
      );
   end

   for (gi = 0; gi < CHOICE_W; gi++) begin : g_sw
      debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
         .clk        (clk),
         .rst_n      (rst_n),
         .i_raw      (sw_raw[gi]),
         .o_level    (w_sw_level[gi]),
         .o_rise     (w_sw_rise[gi]),
         .o_chg_next (w_sw_chg_next[gi])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_choice_chg <= 1'b0;
      end else begin
         r_choice_chg <= |w_sw_chg_next;
      end
   end

`ifdef GAME_INPUT_AUTOREPEAT_EN
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int REP_W   = $clog2(REP_MAX) + 1;
   localparam logic [REP_W-1:0] DELAY_TERM  = REP_W'(REPEAT_DELAY - 1);
   localparam logic [REP_W-1:0] PERIOD_TERM = REP_W'(REPEAT_PERIOD - 1);

   logic [REP_W-1:0] r_rep_cnt;
   logic             r_rep_periodic;
   logic             r_rep_pulse;
   logic             w_hold;
   logic             w_rep_fire;

   // Held means already high and not falling on this edge, so a release suppresses its own pulse.
   assign w_hold     = w_btn_level[BTN_FLAP] & ~w_btn_chg_next[BTN_FLAP];
   assign w_rep_fire = w_hold & (r_rep_cnt == (r_rep_periodic ? PERIOD_TERM : DELAY_TERM));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rep_cnt      <= '0;
         r_rep_periodic <= 1'b0;
         r_rep_pulse    <= 1'b0;
      end else begin
         r_rep_pulse <= w_rep_fire;
         if (!w_hold) begin
            r_rep_cnt      <= '0;
            r_rep_periodic <= 1'b0;
         end else if (w_rep_fire) begin
            r_rep_cnt      <= '0;
            r_rep_periodic <= 1'b1;
         end else begin
            r_rep_cnt <= r_rep_cnt + 1'b1;
         end
      end
   end

   assign btn_press = w_btn_rise | {{(NUM_BTN-1){1'b0}}, r_rep_pulse};
`else
   assign btn_press = w_btn_rise;
`endif

   assign btn_level  = w_btn_level;
   assign choice     = w_sw_level;
   assign choice_chg = r_choice_chg;

   assign w_unused = &{1'b0, w_sw_rise, w_btn_chg_next, 1'(REPEAT_DELAY), 1'(REPEAT_PERIOD), 1'b0};
endmodule

// File: tb/tb_game_input_cond.sv
// Directed and randomized bench for game_input_cond with a sliding-window debounce model.
module tb_game_input_cond;
   import game_input_pkg::*;

   localparam int DEB  = 4;
   localparam int RDLY = 10;
   localparam int RPER = 5;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] btn_raw;
   logic [2:0] sw_raw;
   logic [3:0] btn_level;
   logic [3:0] btn_press;
   logic [2:0] choice;
   logic       choice_chg;

   always #5 clk = ~clk;

   game_input_cond #(
      .DEBOUNCE_CYCLES (DEB),
      .REPEAT_DELAY    (RDLY),
      .REPEAT_PERIOD   (RPER)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_raw    (btn_raw),
      .sw_raw     (sw_raw),
      .btn_level  (btn_level),
      .btn_press  (btn_press),
      .choice     (choice),
      .choice_chg (choice_chg)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int t_press  = -1;

   // Reference model: a level flips once the last DEB synchronised samples all disagree with it.
   bit   m_s1[7];
   bit   m_s2[7];
   bit   m_stable[7];
   bit   mq[7][$];
   logic [3:0] e_level, e_press;
   logic [2:0] e_choice;
   logic       e_chg;

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input bit r, input logic [3:0] b, input logic [2:0] s);
      bit         old_v[7];
      bit         new_v[7];
      bit         all_diff;
      logic [6:0] raw;
      int         el;
      raw = {s, b};
      if (!r) begin
         for (int ch = 0; ch < 7; ch++) begin
            m_s1[ch] = 1'b0;
            m_s2[ch] = 1'b0;
            m_stable[ch] = 1'b0;
            mq[ch].delete();
         end
         e_level = '0; e_press = '0; e_choice = '0; e_chg = 1'b0;
         t_press = -1;
      end else begin
         for (int ch = 0; ch < 7; ch++) begin
            old_v[ch] = m_stable[ch];
            mq[ch].push_back(m_s2[ch]);
            if (mq[ch].size() > DEB) void'(mq[ch].pop_front());
            all_diff = (mq[ch].size() == DEB);
            for (int k = 0; k < mq[ch].size(); k++)
               if (mq[ch][k] == old_v[ch]) all_diff = 1'b0;
            new_v[ch] = all_diff ? ~old_v[ch] : old_v[ch];
            m_stable[ch] = new_v[ch];
            m_s2[ch] = m_s1[ch];
            m_s1[ch] = raw[ch];
         end
         for (int i = 0; i < 4; i++) begin
            e_level[i] = new_v[i];
            e_press[i] = new_v[i] & ~old_v[i];
         end
         e_chg = 1'b0;
         for (int i = 0; i < 3; i++) begin
            e_choice[i] = new_v[4+i];
            if (new_v[4+i] != old_v[4+i]) e_chg = 1'b1;
         end
`ifdef GAME_INPUT_AUTOREPEAT_EN
         if (e_press[0]) begin
            t_press = cyc;
         end else if (old_v[0] && new_v[0] && t_press >= 0) begin
            el = cyc - t_press;
            if (el >= RDLY && (el - RDLY) % RPER == 0) e_press[0] = 1'b1;
         end
         if (!new_v[0]) t_press = -1;
`endif
      end
   endtask

   task automatic step(input bit r, input logic [3:0] b, input logic [2:0] s);
      rst_n   = r;
      btn_raw = b;
      sw_raw  = s;
      @(posedge clk);
      model_edge(r, b, s);
      #1;
      check("btn_level", btn_level, e_level);
      check("btn_press", btn_press, e_press);
      check("choice", {1'b0, choice}, {1'b0, e_choice});
      check("choice_chg", {3'b000, choice_chg}, {3'b000, e_chg});
      $display("cycle %0d rst_n=%b btn_raw=%b sw_raw=%b -> level=%b press=%b choice=%b chg=%b",
               cyc, r, b, s, btn_level, btn_press, choice, choice_chg);
      cyc++;
   endtask

   initial begin
      int         t0, npress, tfirst, nchg;
      logic [3:0] seen;
      logic [3:0] rb;
      logic [2:0] rs;
      bit         rr;

      for (int i = 0; i < 3; i++) step(1'b0, 4'b0000, 3'b000);
      for (int i = 0; i < 4; i++) step(1'b1, 4'b0000, 3'b000);

      // Clean press then release
      t0 = cyc; npress = 0; tfirst = -1;
      for (int i = 0; i < 12; i++) begin
         step(1'b1, 4'b0001, 3'b000);
         if (btn_press[0]) begin npress++; if (tfirst < 0) tfirst = cyc - 1 - t0; end
      end
      check_int("clean_press_edge", tfirst, 5);
      check_int("clean_press_count", npress, 1);
      npress = 0;
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 4'b0000, 3'b000);
         if (btn_press != 4'b0000) npress++;
      end
      check_int("release_no_pulse", npress, 0);

      // Bounce on quit
      npress = 0;
      step(1'b1, 4'b1000, 3'b000); step(1'b1, 4'b0000, 3'b000);
      step(1'b1, 4'b1000, 3'b000); step(1'b1, 4'b0000, 3'b000);
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 4'b1000, 3'b000);
         if (btn_press[3]) npress++;
      end
      check_int("bounce_press_count", npress, 1);
      for (int i = 0; i < 10; i++) step(1'b1, 4'b0000, 3'b000);

      // Simultaneous start + pause
      seen = '0;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 4'b0110, 3'b000);
         if (btn_press != 4'b0000) seen = btn_press;
      end
      check("simultaneous_press", seen, 4'b0110);
      for (int i = 0; i < 10; i++) step(1'b1, 4'b0000, 3'b000);

      // Choice change, then a short glitch
      nchg = 0;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 4'b0000, 3'b101);
         if (choice_chg) nchg++;
      end
      check_int("choice_chg_count", nchg, 1);
      check({1'b0, choice} == 4'b0101 ? "choice_value" : "choice_value", {1'b0, choice}, 4'b0101);
      nchg = 0;
      step(1'b1, 4'b0000, 3'b111); step(1'b1, 4'b0000, 3'b111);
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 4'b0000, 3'b101);
         if (choice_chg) nchg++;
      end
      check_int("glitch_no_chg", nchg, 0);

      // Reset in the middle of a start-button count
      t0 = cyc; tfirst = -1;
      for (int i = 0; i < 14; i++) begin
         step((i == 3) ? 1'b0 : 1'b1, 4'b0010, 3'b101);
         if (btn_press[1] && tfirst < 0) tfirst = cyc - 1 - t0;
      end
      check_int("reset_midcount_edge", tfirst, 9);
      for (int i = 0; i < 10; i++) step(1'b1, 4'b0000, 3'b101);

      // Long flap hold
      t0 = cyc; npress = 0; tfirst = -1;
      for (int i = 0; i < 52; i++) begin
         step(1'b1, (i < 40) ? 4'b0001 : 4'b0000, 3'b101);
         if (btn_press[0]) begin npress++; if (tfirst < 0) tfirst = cyc - 1 - t0; end
      end
      check_int("hold_first_edge", tfirst, 5);
`ifdef GAME_INPUT_AUTOREPEAT_EN
      check_int("hold_pulse_count", npress, 7);
`else
      check_int("hold_pulse_count", npress, 1);
`endif

      // Randomized slow-toggling lines with occasional resets
      rb = '0; rs = 3'b101;
      for (int i = 0; i < 900; i++) begin
         for (int k = 0; k < 4; k++) if ($urandom_range(0, 9) == 0) rb[k] = ~rb[k];
         for (int k = 0; k < 3; k++) if ($urandom_range(0, 9) == 0) rs[k] = ~rs[k];
         if ($urandom_range(0, 5) == 0) rb[0] = 1'b1;
         rr = ($urandom_range(0, 149) != 0);
         step(rr, rb, rs);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
